trace_checker: RTL and testbench



---
 rtl/trace_checker_if.sv | 35 +++
 rtl/trace_checker.sv | 109 ++++++++++
 tb/tb_trace_checker.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/trace_checker_if.sv
// Bundles the write-back trace port, the reference-entry stream and the checker status.
// The loader/CPU side uses the master modport; the checker uses the slave modport.
interface trace_checker_if #(
  parameter int CNT_W = 32
);
  logic             clear;
  logic [31:0]      debug_wb_pc;
  logic [3:0]       debug_wb_rf_wen;
  logic [4:0]       debug_wb_rf_wnum;
  logic [31:0]      debug_wb_rf_wdata;
  logic             ref_valid;
  logic             ref_ready;
  logic [31:0]      ref_pc;
  logic [4:0]       ref_wnum;
  logic [31:0]      ref_wdata;
  logic             ref_last;
  logic             err;
  logic [1:0]       err_code;
  logic [31:0]      err_pc;
  logic [31:0]      err_exp_pc;
  logic             pass;
  logic [CNT_W-1:0] commit_cnt;

  modport master (
    output clear, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output ref_valid, ref_pc, ref_wnum, ref_wdata, ref_last,
    input  ref_ready, err, err_code, err_pc, err_exp_pc, pass, commit_cnt
  );

  modport slave (
    input  clear, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  ref_valid, ref_pc, ref_wnum, ref_wdata, ref_last,
    output ref_ready, err, err_code, err_pc, err_exp_pc, pass, commit_cnt
  );
endinterface

// File: rtl/trace_checker.sv
// Commit-trace checker: buffers golden reference entries in a FIFO and compares every
// register-file commit against the head, latching the first divergence or a final pass.
module trace_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic           aclk,
  input  logic           aresetn,
  trace_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        last;
  } ref_entry_t;

  ref_entry_t       r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             r_err, r_pass;
  logic [1:0]       r_err_code;
  logic [31:0]      r_err_pc, r_err_exp_pc;
  logic [CNT_W-1:0] r_cnt;

  ref_entry_t  w_head;
  logic        w_full, w_empty, w_push, w_pop, w_commit, w_do_cmp;
  logic [31:0] w_mask;
  logic [1:0]  w_code;

  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_push   = bus.ref_valid && !w_full;
  assign w_commit = (|bus.debug_wb_rf_wen) && (bus.debug_wb_rf_wnum != 5'd0);
  assign w_do_cmp = w_commit && !r_err && !r_pass;
  assign w_pop    = w_do_cmp && !w_empty;
  assign w_head   = r_mem[r_rd_ptr[AW-1:0]];

  // Bytes whose write enable is low are don't-care in the data compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 4; i++) w_mask[8*i +: 8] = {8{bus.debug_wb_rf_wen[i]}};
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_code = 2'b00;
    if (w_empty)
      w_code = 2'b11;
    else if (bus.debug_wb_pc != w_head.pc)
      w_code = 2'b01;
    else if ((bus.debug_wb_rf_wnum != w_head.wnum) ||
             (|((bus.debug_wb_rf_wdata ^ w_head.wdata) & w_mask)))
      w_code = 2'b10;
  end

  // NOTE: the entry storage has no reset; validity is tracked solely by the pointers.
  always_ff @(posedge aclk) begin
    if (w_push && !bus.clear)
      r_mem[r_wr_ptr[AW-1:0]] <= '{pc: bus.ref_pc, wnum: bus.ref_wnum,
                                   wdata: bus.ref_wdata, last: bus.ref_last};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_err_pc     <= '0;
      r_err_exp_pc <= '0;
      r_pass       <= 1'b0;
      r_cnt        <= '0;
    end else if (bus.clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_err        <= 1'b0;
      r_err_code   <= 2'b00;
      r_err_pc     <= '0;
      r_err_exp_pc <= '0;
      r_pass       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_cmp) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (w_code != 2'b00) begin
          r_err        <= 1'b1;
          r_err_code   <= w_code;
          r_err_pc     <= bus.debug_wb_pc;
          r_err_exp_pc <= w_empty ? 32'd0 : w_head.pc;
        end else if (w_head.last) begin
          r_pass <= 1'b1;
        end
      end
    end
  end

  assign bus.ref_ready  = !w_full;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.err_pc     = r_err_pc;
  assign bus.err_exp_pc = r_err_exp_pc;
  assign bus.pass       = r_pass;
  assign bus.commit_cnt = r_cnt;
endmodule

// File: tb/tb_trace_checker.sv
// Directed and randomized bench for trace_checker, checked against a queue-based model
// of the reference trace and the sticky error/pass/counter rules.
module tb_trace_checker;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        last;
  } entry_t;

  logic aclk;
  logic aresetn;
  trace_checker_if #(.CNT_W(CNT_W)) bus ();

  trace_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int checks = 0;
  int errors = 0;

  entry_t      ref_q[$];
  logic        m_err, m_pass;
  logic [1:0]  m_code;
  logic [31:0] m_err_pc, m_exp_pc;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_q.delete();
    m_err = 0; m_pass = 0; m_code = 0; m_err_pc = 0; m_exp_pc = 0; m_cnt = 0;
  endtask

  // Applies the checker's rules to the inputs present just before the coming edge.
  task automatic model_edge();
    bit     commit, push, data_ok;
    entry_t h;
    commit = (bus.debug_wb_rf_wen != 0) && (bus.debug_wb_rf_wnum != 0);
    push   = bus.ref_valid && (ref_q.size() < DEPTH);
    if (bus.clear) begin
      model_reset();
      return;
    end
    if (commit && !m_err && !m_pass) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (ref_q.size() == 0) begin
        m_err = 1; m_code = 2'b11; m_err_pc = bus.debug_wb_pc; m_exp_pc = 0;
      end else begin
        h = ref_q.pop_front();
        data_ok = 1;
        for (int b = 0; b < 4; b++)
          if (bus.debug_wb_rf_wen[b] && (bus.debug_wb_rf_wdata[8*b +: 8] != h.wdata[8*b +: 8]))
            data_ok = 0;
        if (bus.debug_wb_pc != h.pc) begin
          m_err = 1; m_code = 2'b01; m_err_pc = bus.debug_wb_pc; m_exp_pc = h.pc;
        end else if (bus.debug_wb_rf_wnum != h.wnum || !data_ok) begin
          m_err = 1; m_code = 2'b10; m_err_pc = bus.debug_wb_pc; m_exp_pc = h.pc;
        end else if (h.last) begin
          m_pass = 1;
        end
      end
    end
    if (push) ref_q.push_back('{bus.ref_pc, bus.ref_wnum, bus.ref_wdata, bus.ref_last});
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ref_ready"},  32'(bus.ref_ready), 32'(ref_q.size() < DEPTH));
    check({tag, ".err"},        32'(bus.err),        32'(m_err));
    check({tag, ".err_code"},   32'(bus.err_code),   32'(m_code));
    check({tag, ".err_pc"},     bus.err_pc,          m_err_pc);
    check({tag, ".err_exp_pc"}, bus.err_exp_pc,      m_exp_pc);
    check({tag, ".pass"},       32'(bus.pass),       32'(m_pass));
    check({tag, ".commit_cnt"}, 32'(bus.commit_cnt), 32'(m_cnt));
  endtask

  task automatic set_idle();
    bus.clear = 0; bus.ref_valid = 0; bus.ref_pc = 0; bus.ref_wnum = 0;
    bus.ref_wdata = 0; bus.ref_last = 0;
    bus.debug_wb_pc = 0; bus.debug_wb_rf_wen = 0; bus.debug_wb_rf_wnum = 0;
    bus.debug_wb_rf_wdata = 0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic [4:0] wnum,
                          input logic [31:0] wdata, input logic last);
    bus.ref_valid = 1; bus.ref_pc = pc; bus.ref_wnum = wnum;
    bus.ref_wdata = wdata; bus.ref_last = last;
  endtask

  task automatic set_commit(input logic [31:0] pc, input logic [3:0] wen,
                            input logic [4:0] wnum, input logic [31:0] wdata);
    bus.debug_wb_pc = pc; bus.debug_wb_rf_wen = wen;
    bus.debug_wb_rf_wnum = wnum; bus.debug_wb_rf_wdata = wdata;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge aclk);
    #1;
    check_all(tag);
  endtask

  task automatic do_clear();
    set_idle();
    bus.clear = 1;
    step("clear");
    bus.clear = 0;
  endtask

  initial begin
    logic [31:0] keep;
    aresetn = 0;
    set_idle();
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    check_all("reset");
    check("reset.ref_ready_const", 32'(bus.ref_ready), 32'd1);
    aresetn = 1;
    step("post_reset");

    // Three matching commits with ignored commits interleaved; pass after the last.
    set_push(32'hBFC0_0000, 5'd1, 32'h11, 0); step("push0");
    set_push(32'hBFC0_0004, 5'd2, 32'h22, 0); step("push1");
    set_push(32'hBFC0_0008, 5'd3, 32'h33, 1); step("push2");
    set_idle();
    set_commit(32'hBFC0_0000, 4'hF, 5'd1, 32'h11); step("c0");
    set_commit(32'hBFC0_0004, 4'hF, 5'd0, 32'h22); step("c_wnum0");
    set_commit(32'hBFC0_0004, 4'hF, 5'd2, 32'h22); step("c1");
    set_commit(32'h0000_0000, 4'h0, 5'd5, 32'h77); step("c_wen0");
    set_commit(32'hBFC0_0008, 4'hF, 5'd3, 32'h33); step("c2");
    check("t1.pass_const", 32'(bus.pass), 32'd1);
    check("t1.cnt_const",  32'(bus.commit_cnt), 32'd3);
    check("t1.err_const",  32'(bus.err), 32'd0);
    set_idle(); step("t1.idle");

    // Byte enables: masked byte differs (match), then full enables (data mismatch).
    do_clear();
    set_push(32'hBFC0_0020, 5'd4, 32'h1234_5678, 0); step("push_a");
    set_push(32'hBFC0_0024, 5'd4, 32'h1234_5678, 0); step("push_b");
    set_idle();
    set_commit(32'hBFC0_0020, 4'h7, 5'd4, 32'hAB34_5678); step("wen7");
    check("t3.no_err_const", 32'(bus.err), 32'd0);
    set_commit(32'hBFC0_0024, 4'hF, 5'd4, 32'hAB34_5678); step("wenF");
    check("t3.code_const", 32'(bus.err_code), 32'd2);

    // PC mismatch; later commits must not disturb the latched error.
    do_clear();
    set_push(32'hBFC0_000C, 5'd1, 32'h0, 0); step("push_pc");
    set_push(32'hBFC0_0010, 5'd1, 32'h0, 0); step("push_pc2");
    set_idle();
    set_commit(32'hBFC0_0010, 4'hF, 5'd1, 32'h0); step("pc_mis");
    check("t4.err_pc_const",  bus.err_pc, 32'hBFC0_0010);
    check("t4.exp_pc_const",  bus.err_exp_pc, 32'hBFC0_000C);
    set_commit(32'hBFC0_0010, 4'hF, 5'd1, 32'h0); step("pc_after1");
    set_commit(32'h1234_0000, 4'h1, 5'd9, 32'h5); step("pc_after2");
    check("t4.cnt_frozen", 32'(bus.commit_cnt), 32'd1);

    // Underflow: commit and push on an empty FIFO in the same cycle.
    do_clear();
    set_push(32'hBFC0_0100, 5'd2, 32'h9, 0);
    set_commit(32'hBFC0_0100, 4'hF, 5'd2, 32'h9); step("underflow");
    check("t5.code_const", 32'(bus.err_code), 32'd3);
    check("t5.exp_const",  bus.err_exp_pc, 32'd0);

    // Fill after the error; a commit while full neither pops nor admits a push.
    set_idle();
    for (int i = 1; i < DEPTH; i++) begin
      set_push(32'hC000_0000 + 32'(i), 5'd1, 32'(i), 0); step("fill");
    end
    check("t6.full_const", 32'(bus.ref_ready), 32'd0);
    set_commit(32'hC000_0001, 4'hF, 5'd1, 32'd1); step("full_commit");
    set_idle();
    set_push(32'hC000_0009, 5'd1, 32'd9, 0); step("full_hold");
    check("t6.still_full", 32'(bus.ref_ready), 32'd0);

    // Asynchronous reset mid-cycle clears everything immediately.
    #2;
    aresetn = 0;
    #1;
    model_reset();
    check_all("midreset");
    check("midreset.ready_const", 32'(bus.ref_ready), 32'd1);
    @(posedge aclk);
    #1;
    set_idle();
    aresetn = 1;
    step("post_midreset");

    // Counter saturation: stream matching entries while committing them.
    for (int k = 0; k <= 20; k++) begin
      set_idle();
      if (k < 20) set_push(32'hA000_0000 + 32'(4*k), 5'd7, 32'(k * 3), 0);
      if (k >= 1) set_commit(32'hA000_0000 + 32'(4*(k-1)), 4'hF, 5'd7, 32'((k-1) * 3));
      step("sat");
    end
    check("sat.cnt_const", 32'(bus.commit_cnt), 32'(CNT_MAX));
    check("sat.err_const", 32'(bus.err), 32'd0);

    // Randomized traffic against the model.
    do_clear();
    for (int n = 0; n < 400; n++) begin
      set_idle();
      if ((m_err || m_pass) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0))
        bus.clear = 1;
      if ($urandom_range(0, 1) == 0)
        set_push($urandom, 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 5) begin
        if (ref_q.size() > 0 && $urandom_range(0, 9) < 9) begin
          logic [3:0]  wen;
          logic [31:0] msk;
          wen = 4'($urandom_range(0, 15));
          msk = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
          keep = ref_q[0].wdata ^ ($urandom & ~msk);
          set_commit(ref_q[0].pc, wen, ref_q[0].wnum, keep);
          if ($urandom_range(0, 19) == 0) bus.debug_wb_pc = bus.debug_wb_pc ^ 32'h4;
          if ($urandom_range(0, 19) == 0) bus.debug_wb_rf_wdata = bus.debug_wb_rf_wdata ^ 32'h0101_0101;
        end else begin
          set_commit($urandom, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), $urandom);
        end
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
